// File: rtl/morse_pkg.sv
// -----------------------------------------------------------------------------
// morse_pkg
// Shared definitions for the Morse word player: 2-bit symbol codes, FSM state
// encoding and the fixed letter/word gap lengths (in Morse time units).
// -----------------------------------------------------------------------------
package morse_pkg;

  typedef enum logic [1:0] {
    SYM_END  = 2'b00,
    SYM_DOT  = 2'b01,
    SYM_DASH = 2'b10,
    SYM_LGAP = 2'b11
  } sym_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DECODE = 3'd1,
    ST_MARK   = 3'd2,
    ST_SPACE  = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  localparam int LETTER_GAP_UNITS = 3;
  localparam int WORD_GAP_UNITS   = 7;

  // Width of the per-interval unit down-counter.
  localparam int UCW = 8;

endpackage

// File: rtl/morse_sequencer_if.sv
// -----------------------------------------------------------------------------
// morse_sequencer_if
// Request/status handshake between the register file and the Morse player.
//   start       request, accepted only while the player is idle
//   pattern     2*NSYM bits of symbols, MSB pair played first
//   busy        high while a word is being played
//   done        one-cycle pulse at the end of a word
//   repeat_word (only with MORSE_REPEAT_EN) loop the word instead of finishing
// -----------------------------------------------------------------------------
interface morse_sequencer_if #(
  parameter int NSYM = 5
);
  logic                start;
  logic [2*NSYM-1:0]   pattern;
  logic                busy;
  logic                done;
`ifdef MORSE_REPEAT_EN
  logic                repeat_word;

  modport master (output start, pattern, repeat_word, input busy, done);
  modport slave  (input start, pattern, repeat_word, output busy, done);
`else
  modport master (output start, pattern, input busy, done);
  modport slave  (input start, pattern, output busy, done);
`endif
endinterface

// File: rtl/morse_sequencer_prescaler.sv
// -----------------------------------------------------------------------------
// unit_prescaler
// Divides clk down to one tick per Morse time unit (every DIV cycles) while
// run is high. clr holds the count at zero so every interval starts aligned.
//   clk, reset (async, active-low)
//   clr      synchronous clear of the count
//   run      count enable (player is in a mark or a space)
//   tick     combinational, high on the last cycle of each unit
//   unit_clk toggles after every tick (LED indicator)
// -----------------------------------------------------------------------------
module unit_prescaler #(
  parameter int DIV = 25000000,
  parameter int CW  = 25
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic run,
  output logic tick,
  output logic unit_clk
);

  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] count;

  assign tick = run && (count == LAST);

  // NOTE: sequential state is written only with non-blocking assignments so
  // every register in the block samples the values from before the edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count    <= '0;
      unit_clk <= 1'b0;
    end else begin
      if (clr || tick) begin
        count <= '0;
      end else if (run) begin
        count <= count + CW'(1);
      end
      if (tick) begin
        unit_clk <= ~unit_clk;
      end
    end
  end

endmodule

// File: rtl/morse_sequencer.sv
// -----------------------------------------------------------------------------
// morse_sequencer
// Plays a packed word of 2-bit Morse symbols as timed marks and spaces.
//   clk, reset (async, active-low)
//   bus       morse_sequencer_if.slave: start/pattern in, busy/done out
//   tone      high during a mark
//   short     high during a dot mark
//   l         high during a dash mark
//   unit_clk  toggles on every unit tick while busy
// Optional feature macro: MORSE_REPEAT_EN (word repeat with a 7-unit word gap
// instead of finishing, controlled by bus.repeat_word).
// -----------------------------------------------------------------------------
module morse_sequencer
  import morse_pkg::*;
#(
  parameter int NSYM       = 5,
  parameter int DIV        = 25000000,
  parameter int CW         = 25,
  parameter int DASH_UNITS = 3,
  parameter int GAP_UNITS  = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  morse_sequencer_if.slave        bus,
  output logic                    tone,
  output logic                    short,
  output logic                    l,
  output logic                    unit_clk
);

  localparam int SCW = $clog2(NSYM + 1);

  // Unit counter reload values: counts down to zero, so load units-1.
  localparam logic [UCW-1:0] DOT_LAST  = '0;
  localparam logic [UCW-1:0] DASH_LAST = UCW'(DASH_UNITS - 1);
  localparam logic [UCW-1:0] GAP_LAST  = UCW'(GAP_UNITS - 1);
  localparam logic [UCW-1:0] LGAP_LAST = UCW'(LETTER_GAP_UNITS - 1);
`ifdef MORSE_REPEAT_EN
  localparam logic [UCW-1:0] WGAP_LAST = UCW'(WORD_GAP_UNITS - 1);
`endif

  state_e             state;
  logic [2*NSYM-1:0]  shreg;
  logic [SCW-1:0]     symcount;
  logic [UCW-1:0]     units_left;
  logic               busy_q;
  logic               done_q;
  logic               tick;
  logic               timing;
`ifdef MORSE_REPEAT_EN
  logic [2*NSYM-1:0]  shadow;
`endif

  sym_e top_sym;
  logic word_end;

  assign top_sym  = sym_e'(shreg[2*NSYM-1 -: 2]);
  assign word_end = (symcount == SCW'(NSYM)) || (top_sym == SYM_END);
  assign timing   = (state == ST_MARK) || (state == ST_SPACE);

  assign bus.busy = busy_q;
  assign bus.done = done_q;

  // Count is held at zero outside MARK/SPACE, so each interval starts on a
  // fresh unit boundary and lasts exactly units*DIV cycles.
  unit_prescaler #(
    .DIV (DIV),
    .CW  (CW)
  ) u_prescaler (
    .clk      (clk),
    .reset    (reset),
    .clr      (!timing),
    .run      (timing),
    .tick     (tick),
    .unit_clk (unit_clk)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      shreg      <= '0;
      symcount   <= '0;
      units_left <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      tone       <= 1'b0;
      short      <= 1'b0;
      l          <= 1'b0;
`ifdef MORSE_REPEAT_EN
      shadow     <= '0;
`endif
    end else begin
      // done is a single-cycle pulse; only the DECODE->DONE step raises it.
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            shreg    <= bus.pattern;
            symcount <= '0;
            busy_q   <= 1'b1;
            state    <= ST_DECODE;
`ifdef MORSE_REPEAT_EN
            shadow   <= bus.pattern;
`endif
          end
        end

        ST_DECODE: begin
          if (word_end) begin
`ifdef MORSE_REPEAT_EN
            if (bus.repeat_word) begin
              shreg      <= shadow;
              symcount   <= '0;
              units_left <= WGAP_LAST;
              state      <= ST_SPACE;
            end else begin
              busy_q <= 1'b0;
              done_q <= 1'b1;
              state  <= ST_DONE;
            end
`else
            busy_q <= 1'b0;
            done_q <= 1'b1;
            state  <= ST_DONE;
`endif
          end else begin
            shreg    <= shreg << 2;
            symcount <= symcount + SCW'(1);
            case (top_sym)
              SYM_DOT: begin
                tone       <= 1'b1;
                short      <= 1'b1;
                units_left <= DOT_LAST;
                state      <= ST_MARK;
              end
              SYM_DASH: begin
                tone       <= 1'b1;
                l          <= 1'b1;
                units_left <= DASH_LAST;
                state      <= ST_MARK;
              end
              default: begin  // SYM_LGAP; SYM_END is handled by word_end
                units_left <= LGAP_LAST;
                state      <= ST_SPACE;
              end
            endcase
          end
        end

        ST_MARK: begin
          if (tick) begin
            if (units_left == '0) begin
              tone       <= 1'b0;
              short      <= 1'b0;
              l          <= 1'b0;
              units_left <= GAP_LAST;
              state      <= ST_SPACE;
            end else begin
              units_left <= units_left - UCW'(1);
            end
          end
        end

        ST_SPACE: begin
          if (tick) begin
            if (units_left == '0) begin
              state <= ST_DECODE;
            end else begin
              units_left <= units_left - UCW'(1);
            end
          end
        end

        ST_DONE: state <= ST_IDLE;

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
